// File: rtl/idu_pipe_if.sv
// Purpose: bundles the fetch-side, register-file and execute-side signals of the decode stage.
// Latency: none; this is wiring only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready. The slave modport is the decode stage.
// Ports: in_* and flush come from fetch; rs*_adr/rs*_data go to and from the register file;
//        out_* go to execute.
interface idu_pipe_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_ir;
    logic [PC_WIDTH-1:0] in_pc;
    logic                flush;
    logic [4:0]          rs1_adr;
    logic [4:0]          rs2_adr;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [XLEN-1:0]     out_rs1;
    logic [XLEN-1:0]     out_rs2;
    logic [4:0]          out_rs1_adr;
    logic [4:0]          out_rs2_adr;
    logic [4:0]          out_rd_adr;
    logic [6:0]          out_opcode;
    logic [2:0]          out_funct3;
    logic [6:0]          out_funct7;
    logic [XLEN-1:0]     out_imm;
    logic                out_rd_we;
    logic                out_illegal;

    modport slave (
        input  in_valid, in_ir, in_pc, flush, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_adr, rs2_adr, out_valid, out_pc, out_rs1, out_rs2,
               out_rs1_adr, out_rs2_adr, out_rd_adr, out_opcode, out_funct3,
               out_funct7, out_imm, out_rd_we, out_illegal
    );

    modport master (
        output in_valid, in_ir, in_pc, flush, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_adr, rs2_adr, out_valid, out_pc, out_rs1, out_rs2,
               out_rs1_adr, out_rs2_adr, out_rd_adr, out_opcode, out_funct3,
               out_funct7, out_imm, out_rd_we, out_illegal
    );
endinterface

// File: rtl/idu_pipe.sv
// Purpose: RISC-V instruction decode stage. It has a valid/ready output register, flush,
//          load-use interlock, illegal-instruction detection and a saturating stall counter.
// Latency: 1 cycle from capture to out_valid. Register-file addresses are combinational from in_ir.
// Backpressure: in_ready = ~flush & ~hazard & (~out_valid | out_ready). It never looks at in_valid.
// Ports: clk, resetn (async, active-low); bus (idu_pipe_if.slave); stall_count (32-bit, saturating).
module idu_pipe #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32,
    parameter bit RV32E    = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    idu_pipe_if.slave   bus,
    output logic [31:0] stall_count
);
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign ir     = bus.in_ir;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    assign bus.rs1_adr = rs1;
    assign bus.rs2_adr = rs2;

    // Every immediate is first built as 32 signed bits. The size cast then sign-extends it to XLEN.
    // zimm has bit 31 clear, so the same cast zero-extends it.
    logic signed [31:0] imm32;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic               illegal;

    always_comb begin
        imm32     = '0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = (ir[1:0] != 2'b11);
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                imm32     = {ir[31:12], 12'b0};
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm32     = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                imm32     = {{20{ir[31]}}, ir[31:20]};
                writes_rd = 1'b1;
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                imm32    = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
                uses_rs2 = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
            end
            OPC_LOAD: begin
                imm32     = {{20{ir[31]}}, ir[31:20]};
                writes_rd = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
            end
            OPC_STORE: begin
                imm32    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                uses_rs2 = 1'b1;
                if (funct3 >= 3'b011) illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                imm32     = {{20{ir[31]}}, ir[31:20]};
                writes_rd = 1'b1;
            end
            OPC_OP: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
                if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
            end
            OPC_MISC_MEM: begin
            end
            OPC_SYSTEM: begin
                imm32     = {27'b0, ir[19:15]};
                uses_rs1  = ~funct3[2];   // CSR*I forms carry zimm in the rs1 field
                writes_rd = (funct3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase
        if (RV32E && ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (writes_rd && rd[4])))
            illegal = 1'b1;
    end

    // Load-use hazard: the held instruction is a load whose result the incoming one reads.
    logic hazard;
    logic capture;

    assign hazard = bus.out_valid && (bus.out_opcode == OPC_LOAD) && bus.out_rd_we &&
                    ((uses_rs1 && (rs1 == bus.out_rd_adr)) ||
                     (uses_rs2 && (rs2 == bus.out_rd_adr)));

    assign bus.in_ready = ~bus.flush & ~hazard & (~bus.out_valid | bus.out_ready);
    assign capture      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= '0;
            bus.out_rs1     <= '0;
            bus.out_rs2     <= '0;
            bus.out_rs1_adr <= '0;
            bus.out_rs2_adr <= '0;
            bus.out_rd_adr  <= '0;
            bus.out_opcode  <= '0;
            bus.out_funct3  <= '0;
            bus.out_funct7  <= '0;
            bus.out_imm     <= '0;
            bus.out_rd_we   <= 1'b0;
            bus.out_illegal <= 1'b0;
            stall_count     <= '0;
        end else begin
            if (bus.flush)          bus.out_valid <= 1'b0;
            else if (capture)       bus.out_valid <= 1'b1;
            else if (bus.out_ready) bus.out_valid <= 1'b0;

            if (capture) begin
                bus.out_pc      <= bus.in_pc;
                bus.out_rs1     <= bus.rs1_data;
                bus.out_rs2     <= bus.rs2_data;
                bus.out_rs1_adr <= rs1;
                bus.out_rs2_adr <= rs2;
                bus.out_rd_adr  <= rd;
                bus.out_opcode  <= opcode;
                bus.out_funct3  <= funct3;
                bus.out_funct7  <= funct7;
                bus.out_imm     <= XLEN'(imm32);
                bus.out_rd_we   <= writes_rd && (rd != 5'd0) && !illegal;
                bus.out_illegal <= illegal;
            end

            if (bus.in_valid && hazard && !bus.flush && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_idu_pipe.sv
module tb_idu_pipe;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] stall_count;
    logic [31:0] stall_count_e;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    idu_pipe_if #(.XLEN(32), .PC_WIDTH(32)) bus ();
    idu_pipe_if #(.XLEN(32), .PC_WIDTH(32)) bus_e ();

    idu_pipe #(.XLEN(32), .PC_WIDTH(32), .RV32E(1'b0)) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .stall_count(stall_count));
    idu_pipe #(.XLEN(32), .PC_WIDTH(32), .RV32E(1'b1)) dut_e (
        .clk(clk), .resetn(resetn), .bus(bus_e), .stall_count(stall_count_e));

    // The RV32E instance sees the same stimulus as the main one.
    assign bus_e.in_valid  = bus.in_valid;
    assign bus_e.in_ir     = bus.in_ir;
    assign bus_e.in_pc     = bus.in_pc;
    assign bus_e.flush     = bus.flush;
    assign bus_e.rs1_data  = bus.rs1_data;
    assign bus_e.rs2_data  = bus.rs2_data;
    assign bus_e.out_ready = bus.out_ready;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63,
                           LD = 7'h03, ST = 7'h23, OPI = 7'h13, OP = 7'h33, MM = 7'h0F, SYS = 7'h73;
    localparam logic [6:0] OPS [11] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP, MM, SYS};

    typedef struct packed {
        logic [31:0] imm;
        logic        u1, u2, rd_we, ill;
    } dec_t;

    typedef struct packed {
        logic [31:0] ir, pc, r1, r2, imm;
        logic        rd_we, ill;
    } exp_t;

    exp_t        m;
    logic        m_valid;
    logic [31:0] m_stall;

    // Reference decode, written directly from the instruction-set rules using arithmetic on fields.
    function automatic dec_t ref_dec(logic [31:0] ir, bit e);
        dec_t        d;
        logic [6:0]  op = ir[6:0];
        logic [2:0]  f3 = ir[14:12];
        logic [6:0]  f7 = ir[31:25];
        int          s = $signed(ir);
        int          hi;
        int          top;
        bit          wr;
        bit          legal_op;
        d   = '0;
        hi  = s >>> 25;
        top = s >>> 31;
        legal_op = op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP, MM, SYS};
        d.u1 = !(op inside {LUI, AUIPC, JAL}) && !(op == SYS && f3[2]);
        d.u2 = op inside {BR, ST, OP};
        wr   = (op inside {LUI, AUIPC, JAL, JALR, LD, OPI, OP}) || (op == SYS && f3 != 3'd0);
        if (op inside {OPI, LD, JALR}) d.imm = s >>> 20;
        else if (op == ST)             d.imm = hi * 32 + ir[11:7];
        else if (op == BR)             d.imm = top * 4096 + ir[7] * 2048 + ir[30:25] * 32 + ir[11:8] * 2;
        else if (op inside {LUI, AUIPC}) d.imm = ir & 32'hFFFF_F000;
        else if (op == JAL)            d.imm = top * 1048576 + ir[19:12] * 4096 + ir[20] * 2048 + ir[30:21] * 2;
        else if (op == SYS)            d.imm = 32'(ir[19:15]);
        d.ill = (ir[1:0] != 2'b11) || !legal_op ||
                (op == JALR && f3 != 3'd0) ||
                (op == BR && f3 inside {3'd2, 3'd3}) ||
                (op == LD && f3 inside {3'd3, 3'd6, 3'd7}) ||
                (op == ST && f3 >= 3'd3) ||
                (op == OP && !(f7 inside {7'h00, 7'h20})) ||
                (op == OP && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) ||
                (e && ((d.u1 && ir[19]) || (d.u2 && ir[24]) || (wr && ir[11])));
        d.rd_we = wr && (ir[11:7] != 5'd0) && !d.ill;
        return d;
    endfunction

    function automatic logic [31:0] rand_ir();
        int         k = $urandom_range(0, 11);
        int         k7 = $urandom_range(0, 3);
        logic [6:0] op;
        logic [6:0] f7;
        op = (k == 11) ? 7'($urandom) : OPS[k];
        f7 = (k7 == 0) ? 7'h00 : (k7 == 1) ? 7'h20 : 7'($urandom);
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom_range(0, 7)), op};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid",   bus.out_valid,   m_valid);
        chk("out_pc",      bus.out_pc,      m.pc);
        chk("out_rs1",     bus.out_rs1,     m.r1);
        chk("out_rs2",     bus.out_rs2,     m.r2);
        chk("out_rs1_adr", bus.out_rs1_adr, m.ir[19:15]);
        chk("out_rs2_adr", bus.out_rs2_adr, m.ir[24:20]);
        chk("out_rd_adr",  bus.out_rd_adr,  m.ir[11:7]);
        chk("out_opcode",  bus.out_opcode,  m.ir[6:0]);
        chk("out_funct3",  bus.out_funct3,  m.ir[14:12]);
        chk("out_funct7",  bus.out_funct7,  m.ir[31:25]);
        chk("out_imm",     bus.out_imm,     m.imm);
        chk("out_rd_we",   bus.out_rd_we,   m.rd_we);
        chk("out_illegal", bus.out_illegal, m.ill);
        chk("stall_count", stall_count,     m_stall);
    endtask

    task automatic model_reset();
        m       = '0;
        m_valid = 1'b0;
        m_stall = '0;
    endtask

    task automatic drive(logic v, logic [31:0] ir, logic [31:0] pc, logic ordy, logic fl);
        bus.in_valid  = v;
        bus.in_ir     = ir;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.rs1_data  = $urandom;
        bus.rs2_data  = $urandom;
    endtask

    // One clock: check the combinational outputs mid-cycle, advance the model, check the registers.
    task automatic cycle();
        dec_t d = ref_dec(bus.in_ir, 1'b0);
        logic hz, rdy, cap;
        hz  = m_valid && (m.ir[6:0] == LD) && m.rd_we &&
              ((d.u1 && bus.in_ir[19:15] == m.ir[11:7]) || (d.u2 && bus.in_ir[24:20] == m.ir[11:7]));
        rdy = !bus.flush && !hz && (!m_valid || bus.out_ready);
        cap = bus.in_valid && rdy;
        @(negedge clk);
        chk("in_ready", bus.in_ready, rdy);
        chk("rs1_adr",  bus.rs1_adr,  bus.in_ir[19:15]);
        chk("rs2_adr",  bus.rs2_adr,  bus.in_ir[24:20]);
        if (bus.in_valid && hz && !bus.flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (cap) m = '{ir: bus.in_ir, pc: bus.in_pc, r1: bus.rs1_data, r2: bus.rs2_data,
                       imm: d.imm, rd_we: d.rd_we, ill: d.ill};
        m_valid = bus.flush ? 1'b0 : cap ? 1'b1 : bus.out_ready ? 1'b0 : m_valid;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check_out();
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out();
        chk("reset_in_ready", bus.in_ready, 1'b1);
        resetn = 1'b1;

        // RV32E: x16 as destination is illegal only in the reduced-register instance.
        drive(1'b1, 32'h0000_0813, 32'h40, 1'b1, 1'b0);
        cycle();
        chk("e_illegal", bus_e.out_illegal, 1'b1);
        chk("e_rd_we",   bus_e.out_rd_we,   1'b0);

        // addi x1,x2,-5 followed by backpressure on a second instruction.
        do_reset();
        drive(1'b1, 32'hFFB1_0093, 32'h100, 1'b1, 1'b0);
        chk("comb_rs1_adr", bus.rs1_adr, 5'd2);
        cycle();
        chk("addi_imm",   bus.out_imm,    32'hFFFF_FFFB);
        chk("addi_rd",    bus.out_rd_adr, 5'd1);
        chk("addi_rd_we", bus.out_rd_we,  1'b1);
        drive(1'b1, 32'h0072_8333, 32'h104, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("bp_hold_pc", bus.out_pc, 32'h100);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_next_pc", bus.out_pc, 32'h104);

        // Flush with a held instruction and a pending offer: no capture, output invalidated.
        drive(1'b1, 32'h0000_0013, 32'h200, 1'b0, 1'b1);
        cycle();
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_pc",    bus.out_pc,    32'h104);

        // Load-use: exactly one bubble and one stall cycle.
        do_reset();
        drive(1'b1, 32'h0000_A283, 32'h300, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h0072_8333, 32'h304, 1'b1, 1'b0);
        cycle();
        chk("lu_bubble", bus.out_valid, 1'b0);
        chk("lu_stall",  stall_count,   32'd1);
        cycle();
        chk("lu_add_pc", bus.out_pc,    32'h304);

        // Same sequence with the load writing x0: no interlock.
        do_reset();
        drive(1'b1, 32'h0000_A003, 32'h400, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h0072_8333, 32'h404, 1'b1, 1'b0);
        cycle();
        chk("lu0_pc",    bus.out_pc,  32'h404);
        chk("lu0_stall", stall_count, 32'd0);

        // All-zero word is illegal and never writes a register.
        drive(1'b1, 32'h0, 32'h500, 1'b1, 1'b0);
        cycle();
        chk("zero_illegal", bus.out_illegal, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_ir(), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0));
            cycle();
        end

        // Reset in the middle of back-to-back traffic.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rand_ir(), 32'h600 + 32'(i * 4), 1'b1, 1'b0);
            cycle();
        end
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_out();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(1'b1, 32'hFFB1_0093, 32'h700, 1'b1, 1'b0);
        cycle();
        chk("post_rst_imm", bus.out_imm, 32'hFFFF_FFFB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
